// File: rtl/ble_pkt_loader.sv
// ble_pkt_loader: SPI-fed BLE packet slot loader with independent byte streamer; define BLE_PKT_CHECKSUM_EN to enable the XOR checksum byte
module ble_pkt_loader #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 64,
    parameter int SLOTS   = 2
) (
    input  logic              pll_clko,
    input  logic              ble_rst,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic [SLOTS-1:0]  slot_valid_o,
    output logic              tx_busy_o,
    output logic              err_o
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam int AW = SLOTS * MAX_LEN > 1 ? $clog2(SLOTS * MAX_LEN) : 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SLOT = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_TSEL = 3'd5;
`ifdef BLE_PKT_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
    logic [DATA_W-1:0] csum_q, csum_d;
`endif
    logic [2:0]        state_q, state_d;
    logic [SW-1:0]     wslot_q, wslot_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [SLOTS-1:0]  slot_valid_q, slot_valid_d;
    logic              err_q, err_d;
    logic              mem_we, len_we, tx_start;
    logic [DATA_W-1:0] mem_q [SLOTS*MAX_LEN];
    logic [LW-1:0]     len_q [SLOTS];
    logic              tx_busy_q, out_valid_q, out_last_q;
    logic [SW-1:0]     tx_slot_q;
    logic [LW-1:0]     rd_idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic [AW-1:0]     waddr, raddr;
    logic              slot_ok, len_ok, tsel_ok, data_end, ld, done;

    assign slot_ok  = rx_data_i < DATA_W'(SLOTS) && !(tx_busy_q && rx_data_i[SW-1:0] == tx_slot_q);
    assign len_ok   = rx_data_i != '0 && rx_data_i <= DATA_W'(MAX_LEN);
    assign tsel_ok  = rx_data_i < DATA_W'(SLOTS) && slot_valid_q[rx_data_i[SW-1:0]] && !tx_busy_q;
    assign data_end = idx_q + 1'b1 == len_q[wslot_q];
    assign waddr    = AW'(wslot_q) * AW'(MAX_LEN) + AW'(idx_q);
    assign raddr    = AW'(tx_slot_q) * AW'(MAX_LEN) + AW'(rd_idx_q);
    assign ld       = tx_busy_q && rd_idx_q != len_q[tx_slot_q] && (!out_valid_q || out_ready_i);
    assign done     = out_valid_q && out_ready_i && out_last_q;

    // Command parser: advances one state per received byte
    always_comb begin
        state_d      = state_q;
        wslot_d      = wslot_q;
        idx_d        = idx_q;
        slot_valid_d = slot_valid_q;
        err_d        = 1'b0;
        mem_we       = 1'b0;
        len_we       = 1'b0;
        tx_start     = 1'b0;
`ifdef BLE_PKT_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (rx_valid_i) begin
            case (state_q)
                S_IDLE: state_d = rx_data_i == DATA_W'(8'hAA) ? S_SLOT :
                                  rx_data_i == DATA_W'(8'h55) ? S_TSEL : S_IDLE;
                S_SLOT: begin
                    wslot_d = slot_ok ? rx_data_i[SW-1:0] : wslot_q;
                    state_d = slot_ok ? S_LEN : S_IDLE;
                    err_d   = !slot_ok;
                end
                S_LEN: begin
                    len_we  = len_ok;
                    idx_d   = '0;
                    state_d = len_ok ? S_DATA : S_IDLE;
                    err_d   = !len_ok;
                    if (len_ok) slot_valid_d[wslot_q] = 1'b0;
`ifdef BLE_PKT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
                S_DATA: begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
`ifdef BLE_PKT_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = data_end ? S_CHK : S_DATA;
`else
                    state_d = data_end ? S_IDLE : S_DATA;
                    if (data_end) slot_valid_d[wslot_q] = 1'b1;
`endif
                end
`ifdef BLE_PKT_CHECKSUM_EN
                S_CHK: begin
                    state_d = S_IDLE;
                    err_d   = rx_data_i != csum_q;
                    if (rx_data_i == csum_q) slot_valid_d[wslot_q] = 1'b1;
                end
`endif
                S_TSEL: begin
                    tx_start = tsel_ok;
                    err_d    = !tsel_ok;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Parser state registers
    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) begin
            state_q      <= S_IDLE;
            wslot_q      <= '0;
            idx_q        <= '0;
            slot_valid_q <= '0;
            err_q        <= 1'b0;
`ifdef BLE_PKT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wslot_q      <= wslot_d;
            idx_q        <= idx_d;
            slot_valid_q <= slot_valid_d;
            err_q        <= err_d;
`ifdef BLE_PKT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Packet memory and per-slot lengths; deliberately not reset
    always_ff @(posedge pll_clko) begin
        if (mem_we) mem_q[waddr] <= rx_data_i;
        if (len_we) len_q[wslot_q] <= LW'(rx_data_i);
    end

    // Streamer: memory read lands directly in the output register, refilled only when it is empty or draining
    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) begin
            tx_busy_q   <= 1'b0;
            tx_slot_q   <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (done) begin
                tx_busy_q   <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (ld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[raddr];
                out_last_q  <= rd_idx_q + 1'b1 == len_q[tx_slot_q];
                rd_idx_q    <= rd_idx_q + 1'b1;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (tx_start) begin
                tx_busy_q <= 1'b1;
                tx_slot_q <= rx_data_i[SW-1:0];
                rd_idx_q  <= '0;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign slot_valid_o = slot_valid_q;
    assign tx_busy_o    = tx_busy_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_ble_pkt_loader.sv
// tb_ble_pkt_loader: scoreboard bench for ble_pkt_loader (BLE_PKT_CHECKSUM_EN optional)
module tb_ble_pkt_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid, out_last, tx_busy, err;
    logic [7:0] out_data;
    logic [1:0] slot_valid;

    ble_pkt_loader #(.DATA_W(8), .MAX_LEN(64), .SLOTS(2)) dut (
        .pll_clko(clk), .ble_rst(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready), .slot_valid_o(slot_valid), .tx_busy_o(tx_busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0, err_cnt = 0, stall_cnt = 0, e = 0;
    logic       done = 1'b0, stalled = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] exp_q[$];
    logic [7:0] pkt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] s, input int n);
`ifdef BLE_PKT_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x ^= pkt[i];
`endif
        send(8'hAA);
        send(s);
        send(8'(n));
        for (int i = 0; i < n; i++) send(pkt[i]);
`ifdef BLE_PKT_CHECKSUM_EN
        send(x);
`endif
    endtask

    task automatic push_pkt(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, pkt[i]});
    endtask

    task automatic drain(input string nm, input int lim);
        int k = 0;
        while ((exp_q.size() != 0 || tx_busy) && k < lim) begin
            @(posedge clk);
            #1 k++;
        end
        chk(nm, 32'(k < lim), 32'd1);
    endtask

    task automatic mon_step();
        logic [8:0] x;
        if (err) err_cnt++;
        if (stalled) begin
            stall_cnt++;
            total++;
            if (!out_valid || {out_last, out_data} !== held) begin
                bad++;
                $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, {out_last, out_data}, held);
            end
        end
        stalled = rst_n && out_valid && !out_ready;
        held    = {out_last, out_data};
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %h expected none", {out_last, out_data});
            end else begin
                x = exp_q.pop_front();
                if ({out_last, out_data} !== x) begin
                    bad++;
                    $display("FAIL stream_byte: got last=%0b data=%h expected last=%0b data=%h", out_last, out_data, x[8], x[7:0]);
                end
            end
        end
    endtask

    initial begin
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    mon_step();
                end
            end
            begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(out_valid), 0);
                chk("rst_outs", {out_last, tx_busy, err, slot_valid, out_data}, 0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                idle(1);

                pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
                load(8'h00, 3);
                chk("load_slot_valid", 32'(slot_valid), 32'h1);
                push_pkt(3);
                send(8'h55); send(8'h00);
                chk("first_latency_valid", 32'(out_valid), 0);
                chk("first_busy", 32'(tx_busy), 1);
                drain("drain_basic", 30);
                chk("retain_valid", 32'(slot_valid), 32'h1);
                idle(1);
                chk("no_err_basic", 32'(err_cnt), 0);

                e = err_cnt;
                send(8'hAA); send(8'h02);
                idle(2);
                chk("bad_slot_err", 32'(err_cnt), 32'(e + 1));
                chk("bad_slot_valid", 32'(slot_valid), 32'h1);
                push_pkt(3);
                send(8'h55); send(8'h00);
                drain("drain_retx", 30);

                e = err_cnt;
                send(8'hAA); send(8'h00); send(8'h00);
                idle(2);
                chk("len0_err", 32'(err_cnt), 32'(e + 1));
                send(8'hAA); send(8'h00); send(8'h41);
                idle(2);
                chk("len65_err", 32'(err_cnt), 32'(e + 2));
                chk("len_err_valid", 32'(slot_valid), 32'h1);
                push_pkt(3);
                send(8'h55); send(8'h00);
                drain("drain_no_write", 30);

                for (int i = 0; i < 6; i++) pkt[i] = 8'(i + 1);
                load(8'h00, 6);
                push_pkt(6);
                send(8'h55); send(8'h00);
                idle(3);
                e = err_cnt;
                fork
                    begin
                        out_ready = 1'b0;
                        idle(5);
                        out_ready = 1'b1;
                    end
                    begin
                        send(8'hAA); send(8'h00);
                        send(8'hAA); send(8'h01); send(8'h02); send(8'h5A); send(8'hA5);
`ifdef BLE_PKT_CHECKSUM_EN
                        send(8'hFF);
`endif
                    end
                join
                drain("drain_stall", 40);
                idle(1);
                chk("busy_slot_err", 32'(err_cnt), 32'(e + 1));
                chk("both_valid", 32'(slot_valid), 32'h3);
                chk("stall_seen", 32'(stall_cnt >= 4), 1);
                exp_q.push_back({1'b0, 8'h5A});
                exp_q.push_back({1'b1, 8'hA5});
                send(8'h55); send(8'h01);
                drain("drain_slot1", 30);

                send(8'hAA); send(8'h01); send(8'h04); send(8'h01); send(8'h02);
                rst_n = 1'b0;
                #1;
                chk("midrst_outs", {out_valid, out_last, tx_busy, err, slot_valid, out_data}, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                idle(1);
                e = err_cnt;
                send(8'h55); send(8'h00);
                idle(2);
                chk("post_rst_tsel0_err", 32'(err_cnt), 32'(e + 1));
                send(8'h55); send(8'h01);
                idle(2);
                chk("post_rst_tsel1_err", 32'(err_cnt), 32'(e + 2));
                chk("post_rst_idle", {30'd0, tx_busy, out_valid}, 0);

`ifdef BLE_PKT_CHECKSUM_EN
                e = err_cnt;
                send(8'hAA); send(8'h00); send(8'h02); send(8'h0F); send(8'hF0); send(8'hFF);
                chk("csum_ok_valid", 32'(slot_valid[0]), 1);
                send(8'hAA); send(8'h00); send(8'h02); send(8'h0F); send(8'hF0); send(8'h00);
                idle(2);
                chk("csum_bad_err", 32'(err_cnt), 32'(e + 1));
                chk("csum_bad_valid", 32'(slot_valid[0]), 0);
`endif
                chk("queue_empty", 32'(exp_q.size()), 0);
                done = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ble_pkt_loader.md
BLE_PKT_LOADER -- requirements
Module: ble_pkt_loader

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the SPI stream and of the packet memory word.
REQ-002 Parameter MAX_LEN, default 64, maximum packet length in bytes per slot.
REQ-003 Parameter SLOTS, default 2, number of independent packet slots; memory depth is SLOTS*MAX_LEN.
REQ-004 Clock and reset: pll_clko input 1, all logic on the rising edge; ble_rst input 1, reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid (from spi_ctrl).
REQ-006 rx_data  input  DATA_W  received SPI byte.
REQ-007 out_valid  output  1  streamed packet byte available.
REQ-008 out_data  output  DATA_W  streamed packet byte.
REQ-009 out_last  output  1  marks the final byte of the packet.
REQ-010 out_ready  input  1  downstream (modulator feeder) accepts the byte.
REQ-011 slot_valid  output  SLOTS  bit n set means slot n holds a complete packet.
REQ-012 tx_busy  output  1  a slot is being streamed.
REQ-013 err  output  1  one-cycle pulse on any protocol error.

Function
REQ-014 Parser states are IDLE, SLOT, LEN, DATA, CHK, TSEL; a state advances only on a cycle with rx_valid=1.
REQ-015 In IDLE, 0xAA goes to SLOT (load), 0x55 goes to TSEL (transmit), and any other byte is ignored without error.
REQ-016 In SLOT, a byte < SLOTS is latched as the write slot and the parser goes to LEN; otherwise err pulses and the parser returns to IDLE.
REQ-017 In SLOT, if the byte names the slot currently being streamed, err pulses and the parser returns to IDLE.
REQ-018 In LEN, a byte L with 1 <= L <= MAX_LEN is latched, the slot's slot_valid bit is cleared, the write index is cleared and the parser goes to DATA.
REQ-019 In LEN, L=0 or L>MAX_LEN pulses err and the parser returns to IDLE.
REQ-020 In DATA, each byte is written to address slot*MAX_LEN+index and the index is incremented.
REQ-021 In DATA, after byte L the parser goes to CHK if checksum is enabled (REQ-033); otherwise it sets slot_valid[slot] and returns to IDLE.
REQ-022 In TSEL, a byte naming a valid slot while tx_busy=0 starts streaming that slot and the parser returns to IDLE; any other byte pulses err and the parser returns to IDLE.
REQ-023 The streamer is independent of the parser, so loads into other slots proceed during streaming.
REQ-024 Memory read latency is 1 cycle; out_valid rises no earlier than 2 cycles after the TSEL byte.
REQ-025 out_data, out_valid and out_last are registered and stay stable while out_valid=1 and out_ready=0.
REQ-026 A byte transfers on a cycle with out_valid=1 and out_ready=1; back-to-back transfers at 1 byte per cycle are sustained while out_ready=1.
REQ-027 out_last=1 only on byte L of the streamed slot; after its transfer, out_valid and tx_busy fall on the next cycle.
REQ-028 slot_valid of the streamed slot remains set after streaming, so the same packet can be retransmitted.
REQ-029 Index and length counters are ceil(log2(MAX_LEN+1)) bits wide; the address never exceeds SLOTS*MAX_LEN-1.

Reset
REQ-030 On ble_rst=0 the parser goes to IDLE, the streamer goes idle, and out_valid=0, out_last=0, out_data=0, slot_valid=0, tx_busy=0 and err=0, all immediately.
REQ-031 Memory contents are not cleared by reset; a reset mid-load or mid-stream abandons the operation and no slot is valid afterwards.
REQ-032 Reset release is synchronous to pll_clko; the first byte is accepted on the first rx_valid after release.

Configuration
REQ-033 With macro BLE_PKT_CHECKSUM_EN defined, DATA is followed by CHK: the received byte is compared to the XOR of the L data bytes; on a match slot_valid[slot] is set, on a mismatch err pulses and the slot stays invalid; the parser then returns to IDLE.
REQ-034 Without BLE_PKT_CHECKSUM_EN, the CHK state and the XOR accumulator do not exist and DATA completes directly.

Verification
REQ-035 Reset, then send AA,00,03,11,22,33 then 55,00 with out_ready=1 -> slot_valid=01; out_data sequence 11,22,33; out_last only on 33.
REQ-036 Send AA,02 with SLOTS=2 -> err pulses once; slot_valid is unchanged and the parser is in IDLE.
REQ-037 Send AA,00,00 and separately AA,00,41 with MAX_LEN=64 -> err on each; no memory write occurs.
REQ-038 Stream slot 0 holding out_ready=0 for 5 cycles mid-packet while loading AA,01,02,5A,A5 -> out_data is held during the stall; slot_valid=11 at the end; AA,00 during the stream gives err.
REQ-039 Assert reset during the DATA phase of a load -> all outputs are 0 immediately; after release, 55,00 gives err.
REQ-040 With BLE_PKT_CHECKSUM_EN, send AA,00,02,0F,F0,FF -> slot valid; repeating with last byte 00 -> err and slot_valid[0]=0.
